branch_resolve_unit: RTL and testbench

- Consumer end of the global branch-prediction interface.
- Carries each D-stage prediction (taken bit, PHT index) down the D→E→M pipeline alongside the branch.
- Resolves the branch in M against the actual outcome and raises a one-cycle flush/redirect on mispredict.
- Emits the PHT/GHT update stream (branchM, actual_takeM, pred_takeM, update index) that the predictor consumes, and keeps branch/mispredict performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 38 +++
 rtl/branch_resolve_unit_if.sv | 24 ++
 rtl/branch_resolve_unit_sat_counter.sv | 22 ++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its predictor link.
package branch_resolve_unit_pkg;

    localparam int unsigned PHT_DEPTH = 14;
    localparam int unsigned XLEN      = 32;

    // 2-bit PHT counter encodings; the predictor side owns the counters.
    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b11,
        STRONGLY_TAKEN     = 2'b10
    } pht_cnt_e;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_e;

    // D->E pipe payload.
    typedef struct packed {
        logic                 branch;
        logic                 pred_take;
        logic [PHT_DEPTH-1:0] index;
        logic [XLEN-1:0]      pc;
    } de_pipe_t;

    // E->M pipe payload.
    typedef struct packed {
        logic                 branch;
        logic                 pred_take;
        logic                 actual_take;
        logic [PHT_DEPTH-1:0] index;
        logic [XLEN-1:0]      target;
        logic [XLEN-1:0]      fallthrough;
    } em_pipe_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction/update link between the global predictor (master) and the resolve unit (slave).
interface branch_resolve_unit_if;
    import branch_resolve_unit_pkg::*;

    logic                 branchD;
    logic                 pred_takeD;
    logic [PHT_DEPTH-1:0] pht_indexD;
    logic [XLEN-1:0]      pcD;

    logic                 branchM;
    logic                 pred_takeM;
    logic                 actual_takeM;
    logic [PHT_DEPTH-1:0] update_PHT_index;

    modport master (
        output branchD, pred_takeD, pht_indexD, pcD,
        input  branchM, pred_takeM, actual_takeM, update_PHT_index
    );

    modport slave (
        input  branchD, pred_takeD, pht_indexD, pcD,
        output branchM, pred_takeM, actual_takeM, update_PHT_index
    );
endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    // Count up on enable, stop at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Carries D-stage predictions to M, resolves them, and requests flush/redirect on mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallD,
    input  logic                   stallE,
    input  logic                   flushE,
    input  logic                   flushM,
    branch_resolve_unit_if.slave   bp,
    input  logic [XLEN-1:0]        branch_targetE,
    input  logic                   actual_takeE,
    output logic                   mispredM,
    output logic                   flush_req,
    output logic [XLEN-1:0]        redirect_pc,
    output logic [CNT_W-1:0]       branch_cnt,
    output logic [CNT_W-1:0]       mispred_cnt
);
    localparam int unsigned REC_W = $clog2(RECOVER_CYCLES + 1);

    de_pipe_t         de_q;
    em_pipe_t         em_q;
    logic             fresh_q;
    bru_state_e       state_q;
    logic [REC_W-1:0] rec_cnt_q;
    logic             flush_req_q;
    logic [XLEN-1:0]  redirect_pc_q;

    logic             branch_valid_c;
    logic             mispred_c;
    logic [XLEN-1:0]  correct_pc_c;

    // D->E register; a flush bubbles it regardless of stall.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            de_q <= '0;
        end else if (!stallD) begin
            de_q <= '{branch:    bp.branchD,
                      pred_take: bp.pred_takeD,
                      index:     bp.pht_indexD,
                      pc:        bp.pcD};
        end
    end

    // E->M register; fresh_q marks the first cycle after a load so a held M entry acts once.
    always_ff @(posedge clk) begin
        if (rst || flushM) begin
            em_q    <= '0;
            fresh_q <= 1'b0;
        end else if (!stallE) begin
            em_q    <= '{branch:      de_q.branch,
                         pred_take:   de_q.pred_take,
                         actual_take: actual_takeE,
                         index:       de_q.index,
                         target:      branch_targetE,
                         fallthrough: XLEN'(de_q.pc + XLEN'(4))};
            fresh_q <= 1'b1;
        end else begin
            fresh_q <= 1'b0;
        end
    end

    // M-stage resolution, gated off while recovering from a mispredict.
    always_comb begin
        branch_valid_c = em_q.branch & fresh_q & (state_q == RUN);
        mispred_c      = branch_valid_c & (em_q.pred_take != em_q.actual_take);
        correct_pc_c   = em_q.actual_take ? em_q.target : em_q.fallthrough;
    end

    // RUN/RECOVER control: squash resolution for RECOVER_CYCLES after a mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            rec_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mispred_c) begin
                        state_q   <= RECOVER;
                        rec_cnt_q <= REC_W'(RECOVER_CYCLES - 1);
                    end
                end
                RECOVER: begin
                    if (rec_cnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        rec_cnt_q <= rec_cnt_q - REC_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // One-cycle flush pulse with the corrected fetch PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_req_q   <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            flush_req_q <= mispred_c;
            if (mispred_c) begin
                redirect_pc_q <= correct_pc_c;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (branch_valid_c),
        .count_o (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mispred_c),
        .count_o (mispred_cnt)
    );

    assign bp.branchM          = branch_valid_c;
    assign bp.pred_takeM       = em_q.pred_take;
    assign bp.actual_takeM     = em_q.actual_take;
    assign bp.update_PHT_index = em_q.index;
    assign mispredM            = mispred_c;
    assign flush_req           = flush_req_q;
    assign redirect_pc         = redirect_pc_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (4-bit counters to reach saturation quickly).
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, stallE, flushE, flushM;
    logic [31:0] branch_targetE;
    logic        actual_takeE;
    logic        mispredM, flush_req;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_b = 4'd0;
    logic [3:0] exp_m = 4'd0;

    branch_resolve_unit_if bp();

    branch_resolve_unit #(.CNT_W(4), .RECOVER_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallD         (stallD),
        .stallE         (stallE),
        .flushE         (flushE),
        .flushM         (flushM),
        .bp             (bp),
        .branch_targetE (branch_targetE),
        .actual_takeE   (actual_takeE),
        .mispredM       (mispredM),
        .flush_req      (flush_req),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one branch into D, supply its E-stage result, and stop with it sitting in M.
    task automatic send_branch(input logic [31:0] pc, input logic pred, input logic act,
                               input logic [31:0] tgt, input logic [13:0] idx);
        bp.branchD = 1'b1; bp.pred_takeD = pred; bp.pcD = pc; bp.pht_indexD = idx;
        tick();
        bp.branchD = 1'b0; actual_takeE = act; branch_targetE = tgt;
        tick();
    endtask

    task automatic check_counts(input string tag);
        total++;
        if (branch_cnt !== exp_b) begin bad++; $display("FAIL %s branch_cnt got=%0d exp=%0d", tag, branch_cnt, exp_b); end
        total++;
        if (mispred_cnt !== exp_m) begin bad++; $display("FAIL %s mispred_cnt got=%0d exp=%0d", tag, mispred_cnt, exp_m); end
    endtask

    task automatic test_reset();
        rst = 1'b1; stallD = 0; stallE = 0; flushE = 0; flushM = 0;
        bp.branchD = 0; bp.pred_takeD = 0; bp.pht_indexD = '0; bp.pcD = '0;
        branch_targetE = '0; actual_takeE = 0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if ({bp.branchM, bp.pred_takeM, bp.actual_takeM, mispredM, flush_req} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000",
                            {bp.branchM, bp.pred_takeM, bp.actual_takeM, mispredM, flush_req});
        end
        total++;
        if (bp.update_PHT_index !== 14'd0) begin bad++; $display("FAIL reset_index got=%h exp=0", bp.update_PHT_index); end
        total++;
        if (redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
        total++;
        if (dut.state_q !== RUN) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, RUN); end
        check_counts("reset");
    endtask

    task automatic test_correct_predict();
        send_branch(32'h100, 1'b1, 1'b1, 32'h200, 14'h5);
        total++;
        if ({bp.branchM, mispredM, bp.pred_takeM, bp.actual_takeM} !== 4'b1011) begin
            bad++; $display("FAIL hit_m got=%b exp=1011", {bp.branchM, mispredM, bp.pred_takeM, bp.actual_takeM});
        end
        total++;
        if (bp.update_PHT_index !== 14'h5) begin bad++; $display("FAIL hit_index got=%h exp=5", bp.update_PHT_index); end
        tick();
        exp_b = 4'd1;
        total++;
        if (flush_req !== 1'b0) begin bad++; $display("FAIL hit_flush got=%b exp=0", flush_req); end
        check_counts("hit");
    endtask

    task automatic test_mispredict_not_taken();
        send_branch(32'h100, 1'b1, 1'b0, 32'h200, 14'h6);
        total++;
        if (mispredM !== 1'b1) begin bad++; $display("FAIL mnt_mispred got=%b exp=1", mispredM); end
        tick();
        exp_b = 4'd2; exp_m = 4'd1;
        total++;
        if (flush_req !== 1'b1) begin bad++; $display("FAIL mnt_flush got=%b exp=1", flush_req); end
        total++;
        if (redirect_pc !== 32'h104) begin bad++; $display("FAIL mnt_redirect got=%h exp=104", redirect_pc); end
        check_counts("mnt");
        tick();
        total++;
        if (flush_req !== 1'b0) begin bad++; $display("FAIL mnt_flush_pulse got=%b exp=0", flush_req); end
        tick();
        total++;
        if (dut.state_q !== RUN) begin bad++; $display("FAIL mnt_state got=%0d exp=%0d", dut.state_q, RUN); end
    endtask

    task automatic test_back_to_back();
        bp.branchD = 1; bp.pred_takeD = 0; bp.pcD = 32'h180; bp.pht_indexD = 14'h7;
        tick();
        bp.branchD = 1; bp.pred_takeD = 1; bp.pcD = 32'h184; bp.pht_indexD = 14'h8;
        actual_takeE = 1; branch_targetE = 32'h340;
        tick();
        bp.branchD = 0; actual_takeE = 0; branch_targetE = 32'h999;
        total++;
        if (mispredM !== 1'b1) begin bad++; $display("FAIL b2b_first_mispred got=%b exp=1", mispredM); end
        tick();
        exp_b = 4'd3; exp_m = 4'd2;
        total++;
        if ({bp.branchM, mispredM} !== 2'b00) begin bad++; $display("FAIL b2b_second_gated got=%b exp=00", {bp.branchM, mispredM}); end
        total++;
        if (redirect_pc !== 32'h340 || flush_req !== 1'b1) begin
            bad++; $display("FAIL b2b_redirect got=%h/%b exp=340/1", redirect_pc, flush_req);
        end
        tick();
        check_counts("b2b");
        tick();
    endtask

    task automatic test_stall_in_m();
        send_branch(32'h200, 1'b0, 1'b0, 32'h300, 14'h9);
        total++;
        if (bp.branchM !== 1'b1) begin bad++; $display("FAIL stall_branchM got=%b exp=1", bp.branchM); end
        stallE = 1'b1;
        exp_b = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bp.branchM !== 1'b0) begin bad++; $display("FAIL stall_held_branchM[%0d] got=%b exp=0", i, bp.branchM); end
            check_counts("stall_held");
        end
        stallE = 1'b0;
        tick();
        check_counts("stall_release");
    endtask

    task automatic test_saturate();
        bp.branchD = 1; bp.pred_takeD = 1; bp.pcD = 32'h400; actual_takeE = 1; branch_targetE = 32'h500;
        repeat (14) tick();
        bp.branchD = 0;
        repeat (3) tick();
        exp_b = 4'd15;
        check_counts("saturate");
    endtask

    task automatic test_reset_mid_recover();
        send_branch(32'h600, 1'b1, 1'b0, 32'h700, 14'hA);
        tick();
        total++;
        if (dut.state_q !== RECOVER) begin bad++; $display("FAIL rmr_in_recover got=%0d exp=%0d", dut.state_q, RECOVER); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_b = 4'd0; exp_m = 4'd0;
        total++;
        if (dut.state_q !== RUN) begin bad++; $display("FAIL rmr_state got=%0d exp=%0d", dut.state_q, RUN); end
        total++;
        if ({flush_req, bp.branchM} !== 2'b00 || redirect_pc !== 32'd0) begin
            bad++; $display("FAIL rmr_outputs got=%b/%h exp=00/0", {flush_req, bp.branchM}, redirect_pc);
        end
        check_counts("rmr");
    endtask

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict_not_taken();
        test_back_to_back();
        test_stall_in_m();
        test_saturate();
        test_reset_mid_recover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
